// File: rtl/decoder_button_pio.sv
// -----------------------------------------------------------------------------
// decoder_button_pio
//   Push-button parallel input port with edge capture and a level interrupt,
//   presented as an Avalon-MM slave with four word registers:
//     0 : data        (read-only, synchronized pin state)
//     1 : reserved    (reads 0, writes ignored)
//     2 : irqmask     (read/write)
//     3 : edgecapture (read, write-1-to-clear)
//
// Parameters
//   WIDTH     : number of input pins / register width (1..32)
//   EDGE_TYPE : 0 = rising, 1 = falling, 2 = any edge sets a capture bit
//
// Ports
//   clk        : single clock for all logic
//   reset      : synchronous, active-high reset
//   address    : 2-bit word address
//   chipselect : slave select
//   write_n    : active-low write strobe (chipselect & write_n = read)
//   writedata  : 32-bit write data (only [WIDTH-1:0] used)
//   in_port    : asynchronous button inputs
//   readdata   : registered read data, one cycle latency, upper bits zero
//   irq        : level interrupt, OR of (edgecapture & irqmask)
// -----------------------------------------------------------------------------
module decoder_button_pio #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned EDGE_TYPE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] s3;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] edge_vec;
   logic [WIDTH-1:0] clear_vec;
   logic [31:0]      read_mux;
   logic             wr_en;
   logic             rd_en;

   // Bits of writedata above WIDTH are intentionally ignored.
   logic             unused_wdata;
   assign unused_wdata = ^writedata;

   assign wr_en = chipselect & ~write_n;
   assign rd_en = chipselect &  write_n;

   // Synchronizer plus one history stage for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_comb begin
      edge_vec = '0;
      case (EDGE_TYPE)
         0:       edge_vec =  s2 & ~s3;
         1:       edge_vec = ~s2 &  s3;
         default: edge_vec =  s2 ^  s3;
      endcase
   end

   always_comb begin
      clear_vec = '0;
      if (wr_en && address == ADDR_EDGE)
         clear_vec = writedata[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irqmask <= '0;
      end else if (wr_en && address == ADDR_MASK) begin
         irqmask <= writedata[WIDTH-1:0];
      end
   end

   // Set is OR-ed after the clear so a coincident edge is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         edgecapture <= '0;
      end else begin
         edgecapture <= (edgecapture & ~clear_vec) | edge_vec;
      end
   end

   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_DATA: read_mux[WIDTH-1:0] = s2;
         ADDR_RSVD: read_mux            = '0;
         ADDR_MASK: read_mux[WIDTH-1:0] = irqmask;
         ADDR_EDGE: read_mux[WIDTH-1:0] = edgecapture;
         default:   read_mux            = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else if (rd_en) begin
         readdata <= read_mux;
      end
   end

   assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_decoder_button_pio.sv
module tb_decoder_button_pio;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        cs0, cs2;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in0, in2;
   logic [31:0] rd0, rd2;
   logic        irq0, irq2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decoder_button_pio #(.WIDTH(8), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
      .write_n(write_n), .writedata(writedata), .in_port(in0),
      .readdata(rd0), .irq(irq0));

   decoder_button_pio #(.WIDTH(8), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs2),
      .write_n(write_n), .writedata(writedata), .in_port(in2),
      .readdata(rd2), .irq(irq2));

   // All tasks start and end right after a falling edge.
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; write_n = 1'b0;
      if (sel) cs2 = 1'b1; else cs0 = 1'b1;
      @(negedge clk);
      cs0 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input bit sel, input logic [1:0] a, output logic [31:0] d);
      address = a; write_n = 1'b1;
      if (sel) cs2 = 1'b1; else cs0 = 1'b1;
      @(negedge clk);
      cs0 = 1'b0; cs2 = 1'b0;
      d = sel ? rd2 : rd0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      n_cmp++;
      if (rd0 !== 32'h0) begin $display("FAIL reset_readdata actual=%h expected=%h", rd0, 32'h0); n_bad++; end
      for (int a = 0; a < 4; a++) begin
         bus_read(1'b0, 2'(a), d);
         n_cmp++;
         if (d !== 32'h0) begin $display("FAIL reset_read_addr%0d actual=%h expected=%h", a, d, 32'h0); n_bad++; end
      end
      n_cmp++;
      if (irq0 !== 1'b0) begin $display("FAIL reset_irq0 actual=%b expected=0", irq0); n_bad++; end
      n_cmp++;
      if (irq2 !== 1'b0) begin $display("FAIL reset_irq2 actual=%b expected=0", irq2); n_bad++; end
   endtask

   task automatic test_rising_capture;
      logic [31:0] d;
      bus_write(1'b0, 2'd2, 32'h01);
      in0 = 8'h01;
      cycles(2);
      n_cmp++;
      if (irq0 !== 1'b0) begin $display("FAIL rise_irq_early actual=%b expected=0", irq0); n_bad++; end
      cycles(1);
      n_cmp++;
      if (irq0 !== 1'b1) begin $display("FAIL rise_irq_on_time actual=%b expected=1", irq0); n_bad++; end
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'h01) begin $display("FAIL rise_edgecapture actual=%h expected=%h", d, 32'h01); n_bad++; end
      bus_read(1'b0, 2'd0, d);
      n_cmp++;
      if (d !== 32'h01) begin $display("FAIL rise_data actual=%h expected=%h", d, 32'h01); n_bad++; end
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'h01 || irq0 !== 1'b1) begin
         $display("FAIL read_no_side_effect actual=%h/%b expected=%h/1", d, irq0, 32'h01); n_bad++;
      end
   endtask

   task automatic test_clear;
      logic [31:0] d;
      bus_write(1'b0, 2'd3, 32'h01);
      n_cmp++;
      if (irq0 !== 1'b0) begin $display("FAIL clear_irq actual=%b expected=0", irq0); n_bad++; end
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'h0) begin $display("FAIL clear_edgecapture actual=%h expected=%h", d, 32'h0); n_bad++; end
      in0 = 8'h00;
      cycles(4);
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'h0 || irq0 !== 1'b0) begin
         $display("FAIL fall_ignored actual=%h/%b expected=%h/0", d, irq0, 32'h0); n_bad++;
      end
   endtask

   task automatic test_regmap;
      logic [31:0] d;
      bus_write(1'b0, 2'd1, 32'hFF);
      bus_read(1'b0, 2'd1, d);
      n_cmp++;
      if (d !== 32'h0) begin $display("FAIL reserved_read actual=%h expected=%h", d, 32'h0); n_bad++; end
      bus_write(1'b0, 2'd0, 32'hAA);
      bus_read(1'b0, 2'd0, d);
      n_cmp++;
      if (d !== 32'h0) begin $display("FAIL data_write_ignored actual=%h expected=%h", d, 32'h0); n_bad++; end
      bus_write(1'b0, 2'd2, 32'hFFFFFF5A);
      bus_read(1'b0, 2'd2, d);
      n_cmp++;
      if (d !== 32'h5A) begin $display("FAIL mask_upper_bits actual=%h expected=%h", d, 32'h5A); n_bad++; end
   endtask

   task automatic test_set_wins;
      logic [31:0] d;
      bus_write(1'b0, 2'd2, 32'h04);
      in0 = 8'h04;
      cycles(3);
      n_cmp++;
      if (irq0 !== 1'b1) begin $display("FAIL bit2_irq actual=%b expected=1", irq0); n_bad++; end
      in0 = 8'h00;
      cycles(3);
      // Rise again; edge lands on the same clock edge as the clear write.
      in0 = 8'h04;
      cycles(2);
      bus_write(1'b0, 2'd3, 32'h04);
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'h04) begin $display("FAIL set_wins actual=%h expected=%h", d, 32'h04); n_bad++; end
      bus_write(1'b0, 2'd3, 32'h04);
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'h0 || irq0 !== 1'b0) begin
         $display("FAIL bit2_clear actual=%h/%b expected=%h/0", d, irq0, 32'h0); n_bad++;
      end
      in0 = 8'h00;
      cycles(4);
   endtask

   task automatic test_any_edge;
      logic [31:0] d;
      bus_write(1'b1, 2'd2, 32'h00);
      in2 = 8'h80;
      cycles(3);
      bus_read(1'b1, 2'd3, d);
      n_cmp++;
      if (d !== 32'h80 || irq2 !== 1'b0) begin
         $display("FAIL any_rise_masked actual=%h/%b expected=%h/0", d, irq2, 32'h80); n_bad++;
      end
      bus_write(1'b1, 2'd2, 32'h80);
      n_cmp++;
      if (irq2 !== 1'b1) begin $display("FAIL any_unmask_irq actual=%b expected=1", irq2); n_bad++; end
      bus_write(1'b1, 2'd3, 32'hFFFFFFFF);
      bus_read(1'b1, 2'd3, d);
      n_cmp++;
      if (d !== 32'h0 || irq2 !== 1'b0) begin
         $display("FAIL any_clear_all actual=%h/%b expected=%h/0", d, irq2, 32'h0); n_bad++;
      end
      in2 = 8'h00;
      cycles(3);
      bus_read(1'b1, 2'd3, d);
      n_cmp++;
      if (d !== 32'h80 || irq2 !== 1'b1) begin
         $display("FAIL any_fall actual=%h/%b expected=%h/1", d, irq2, 32'h80); n_bad++;
      end
      bus_write(1'b1, 2'd3, 32'h80);
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      bus_write(1'b0, 2'd2, 32'hFF);
      in0 = 8'hFF;
      cycles(3);
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'hFF || irq0 !== 1'b1) begin
         $display("FAIL pre_reset_state actual=%h/%b expected=%h/1", d, irq0, 32'hFF); n_bad++;
      end
      reset = 1'b1;
      cycles(1);
      n_cmp++;
      if (rd0 !== 32'h0 || irq0 !== 1'b0 || irq2 !== 1'b0) begin
         $display("FAIL mid_reset actual=%h/%b/%b expected=%h/0/0", rd0, irq0, irq2, 32'h0); n_bad++;
      end
      reset = 1'b0;
      // Pins held high through reset are seen as a rising edge on the
      // third edge after release.
      bus_read(1'b0, 2'd2, d);
      n_cmp++;
      if (d !== 32'h0) begin $display("FAIL reset_mask actual=%h expected=%h", d, 32'h0); n_bad++; end
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'h0) begin $display("FAIL reset_edge_e2 actual=%h expected=%h", d, 32'h0); n_bad++; end
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'h0) begin $display("FAIL reset_edge_e3 actual=%h expected=%h", d, 32'h0); n_bad++; end
      bus_read(1'b0, 2'd3, d);
      n_cmp++;
      if (d !== 32'hFF || irq0 !== 1'b0) begin
         $display("FAIL release_capture actual=%h/%b expected=%h/0", d, irq0, 32'hFF); n_bad++;
      end
   endtask

   initial begin
      reset = 1'b1; cs0 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
      address = 2'd0; writedata = 32'h0; in0 = 8'h00; in2 = 8'h00;
      cycles(3);
      reset = 1'b0;
      test_reset();
      test_rising_capture();
      test_clear();
      test_regmap();
      test_set_wins();
      test_any_edge();
      test_reset_mid();
      cycles(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
